// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit data in, scanned segment/select data out.
// The master side is the timekeeping logic (or a bench); the slave side is
// the scan driver itself.
interface seg_scan_driver_if;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  select_light;
  logic [7:0]  display_char;
  logic        frame_start;

  modport master (
    output digits, dp_mask, blink_mask,
    input  select_light, display_char, frame_start
  );

  modport slave (
    input  digits, dp_mask, blink_mask,
    output select_light, display_char, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an 8-digit seven-segment display.
// A prescaler divides CP into SCAN_DIV-cycle digit slots; the slot index walks
// digit 0..7 continuously. Inputs are copied into shadow registers at every
// frame boundary (slot 7 -> slot 0), so a frame never mixes old and new data.
// Outputs are registered and computed from the post-edge state, so the new
// digit and its freshly latched data appear together one cycle after tick.
//
// Optional feature macro: SEG_BLINK_EN
//   defined     - frame counter, blink phase and blink_mask shadow are built;
//                 digits with their blink bit set go dark while the phase is 1.
//   not defined - blink logic absent, blink_mask ignored, BLINK_FRAMES unused.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic             CP,
  input  logic             _CR,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned      PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  // One state per digit slot; the state value is the digit index.
  typedef enum logic [2:0] {
    DRIVE0 = 3'd0,
    DRIVE1 = 3'd1,
    DRIVE2 = 3'd2,
    DRIVE3 = 3'd3,
    DRIVE4 = 3'd4,
    DRIVE5 = 3'd5,
    DRIVE6 = 3'd6,
    DRIVE7 = 3'd7
  } state_t;

  // Segment glyph {g,f,e,d,c,b,a} for a 4-bit digit code.
  function automatic logic [6:0] seg_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h40;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [PRE_W-1:0] r_pre;
  state_t           r_state;
  logic [31:0]      r_digits;
  logic [7:0]       r_dp;
  logic [7:0]       r_sel;
  logic [7:0]       r_char;
  logic             r_fs;

  logic             w_tick;
  logic             w_boundary;
  state_t           w_state_next;
  logic [2:0]       w_idx_next;
  logic [31:0]      w_digits_next;
  logic [7:0]       w_dp_next;
  logic [3:0]       w_code;
  logic             w_blank_next;
  logic [7:0]       w_char_next;
  logic [7:0]       w_sel_next;

  // Slot timing and next-state view of slot index and digit shadows.
  always_comb begin
    w_tick     = (r_pre == PRE_MAX);
    w_boundary = w_tick && (r_state == DRIVE7);
    if (w_tick) begin
      w_state_next = state_t'(r_state + 3'd1);
    end else begin
      w_state_next = r_state;
    end
    if (w_boundary) begin
      w_digits_next = bus.digits;
      w_dp_next     = bus.dp_mask;
    end else begin
      w_digits_next = r_digits;
      w_dp_next     = r_dp;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned     FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] r_fc;
  logic            r_phase;
  logic [7:0]      r_blink;
  logic            w_phase_next;
  logic [7:0]      w_blink_next;

  // Next blink phase and blink shadow; a counter wrap at the boundary flips
  // the phase in the same edge that loads the new shadows.
  always_comb begin
    if (w_boundary) begin
      w_blink_next = bus.blink_mask;
      if (r_fc == FC_MAX) begin
        w_phase_next = ~r_phase;
      end else begin
        w_phase_next = r_phase;
      end
    end else begin
      w_blink_next = r_blink;
      w_phase_next = r_phase;
    end
    w_blank_next = w_phase_next & w_blink_next[w_idx_next];
  end

  // Frame counter, blink phase and blink-mask shadow.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      r_fc    <= {FC_W{1'b0}};
      r_phase <= 1'b0;
      r_blink <= 8'h00;
    end else begin
      if (w_boundary) begin
        if (r_fc == FC_MAX) begin
          r_fc <= {FC_W{1'b0}};
        end else begin
          r_fc <= r_fc + FC_W'(1);
        end
      end else begin
        r_fc <= r_fc;
      end
      r_phase <= w_phase_next;
      r_blink <= w_blink_next;
    end
  end
`else
  localparam int unsigned UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic w_unused_blink;

  // Without blinking nothing is ever blanked.
  always_comb begin
    w_blank_next   = 1'b0;
    w_unused_blink = ^bus.blink_mask;
  end
`endif

  // Decode the digit that will be shown after the coming edge.
  always_comb begin
    w_idx_next  = w_state_next;
    w_code      = w_digits_next[{w_idx_next, 2'b00} +: 4];
    w_sel_next  = 8'h01 << w_idx_next;
    if (w_blank_next) begin
      w_char_next = 8'h00;
    end else begin
      w_char_next = {w_dp_next[w_idx_next], seg_glyph(w_code)};
    end
  end

  // Prescaler, slot state machine and digit/dp shadow registers.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      r_pre    <= {PRE_W{1'b0}};
      r_state  <= DRIVE7;
      r_digits <= 32'h0000_0000;
      r_dp     <= 8'h00;
    end else begin
      if (w_tick) begin
        r_pre <= {PRE_W{1'b0}};
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_state  <= w_state_next;
      r_digits <= w_digits_next;
      r_dp     <= w_dp_next;
    end
  end

  // Registered outputs: update on tick only, so they stay dark until the
  // first slot after reset and hold steady for the whole slot.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      r_sel  <= 8'h00;
      r_char <= 8'h00;
      r_fs   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_sel  <= w_sel_next;
        r_char <= w_char_next;
      end else begin
        r_sel  <= r_sel;
        r_char <= r_char;
      end
      r_fs <= w_boundary;
    end
  end

  assign bus.select_light = r_sel;
  assign bus.display_char = r_char;
  assign bus.frame_start  = r_fs;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, BLINK_FRAMES=2).
// A cycle-count model derives the expected outputs from the number of clock
// edges since reset release; directed literal checks pin the model.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;

  logic CP  = 1'b0;
  logic _CR = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .CP  (CP),
    ._CR (_CR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: t = edges since reset release; slot s = t/SD.
  int         t = 0;
  logic [31:0] m_dig = 32'h0;
  logic [7:0]  m_dp = 8'h00;
  logic [7:0]  m_bm = 8'h00;

  initial begin
    int s, d, n;
    logic [7:0] e_sel, e_char, e_fs;
    forever begin
      @(posedge CP);
      if (!_CR) begin
        t = 0; m_dig = 32'h0; m_dp = 8'h00; m_bm = 8'h00;
      end else begin
        t = t + 1;
        if ((t % SD) == 0 && (((t / SD) - 1) % 8) == 0) begin
          m_dig = bus.digits; m_dp = bus.dp_mask; m_bm = bus.blink_mask;
        end
      end
      #1;
      s = t / SD;
      if (s == 0) begin
        e_sel = 8'h00; e_char = 8'h00; e_fs = 8'h00;
      end else begin
        d = (s - 1) % 8;
        n = (s - 1) / 8 + 1;
        e_sel  = 8'h01 << d;
        e_char = {m_dp[d], glyph[m_dig[d*4 +: 4]][6:0]};
`ifdef SEG_BLINK_EN
        if (((n / BF) % 2) == 1 && m_bm[d]) e_char = 8'h00;
`endif
        e_fs = ((t % SD) == 0 && d == 0) ? 8'h01 : 8'h00;
      end
      chk8("model_select_light", bus.select_light, e_sel);
      chk8("model_display_char", bus.display_char, e_char);
      chk8("model_frame_start", {7'd0, bus.frame_start}, e_fs);
    end
  end

  // Wait (bounded) until frame_start is seen; returns at posedge+2 of slot 0.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CP); #2;
      if (bus.frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: frame_start not seen within 200 cycles at %0t", $time);
    end
  endtask

  // Check display_char for slots 0..7 of the current frame (slot 0 byte lowest).
  task automatic check_frame(input string name, input logic [63:0] exp);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        repeat (SD) @(posedge CP);
        #2;
      end
      chk8(name, bus.display_char, exp[8*i +: 8]);
    end
  endtask

  initial begin
    logic [7:0] walk;
    int         cnt;
    bus.digits = 32'h0; bus.dp_mask = 8'h00; bus.blink_mask = 8'h00;

    // Reset state.
    repeat (3) @(negedge CP);
    chk8("reset_sel", bus.select_light, 8'h00);
    chk8("reset_char", bus.display_char, 8'h00);
    chk8("reset_fs", {7'd0, bus.frame_start}, 8'h00);
    _CR = 1'b1;

    // First tick after SD edges, then the one-hot walk.
    for (int i = 0; i < 3; i++) begin
      @(posedge CP); #2;
      chk8("pre_tick_sel", bus.select_light, 8'h00);
    end
    @(posedge CP); #2;
    chk8("first_sel", bus.select_light, 8'h01);
    chk8("first_fs", {7'd0, bus.frame_start}, 8'h01);
    walk = 8'h01;
    for (int i = 0; i < 8; i++) begin
      repeat (SD) @(posedge CP); #2;
      walk = {walk[6:0], walk[7]};
      chk8("walk_sel", bus.select_light, walk);
    end

    // Standard glyphs with a decimal point on digit 2.
    @(negedge CP);
    bus.digits = 32'h76543210; bus.dp_mask = 8'h04;
    wait_frame();
    check_frame("glyph_frame", 64'h07_7D_6D_66_4F_DB_06_3F);

    // Codes 8..F: 8, 9, dash, then blanks.
    @(negedge CP);
    bus.digits = 32'hFEDCBA98; bus.dp_mask = 8'h00;
    wait_frame();
    check_frame("code_frame", 64'h00_00_00_00_00_40_6F_7F);

    // Mid-frame change stays invisible until the next frame.
    @(negedge CP);
    bus.digits = 32'h11111111;
    wait_frame();
    repeat (3 * SD) @(posedge CP);
    @(negedge CP);
    bus.digits = 32'h22222222;
    for (int i = 3; i < 8; i++) begin
      if (i > 3) begin
        repeat (SD) @(posedge CP);
        #2;
      end
      chk8("midframe_old", bus.display_char, 8'h06);
    end
    wait_frame();
    chk8("midframe_new", bus.display_char, 8'h5B);

    // Change in the boundary cycle itself is captured.
    repeat (8 * SD - 1) @(posedge CP);
    @(negedge CP);
    bus.digits = 32'h00000003;
    @(posedge CP); #2;
    chk8("boundary_fs", {7'd0, bus.frame_start}, 8'h01);
    chk8("boundary_capture", bus.display_char, 8'h4F);

    // Blink on digits 0-1: over any 4 frames, 2 are dark (or none if disabled).
    @(negedge CP);
    bus.digits = 32'h00000088; bus.blink_mask = 8'h03;
    wait_frame();
    cnt = 0;
    for (int f = 0; f < 4; f++) begin
      wait_frame();
      if (bus.display_char == 8'h00) cnt++;
      chk8("blink_sel", bus.select_light, 8'h01);
    end
`ifdef SEG_BLINK_EN
    chkint("blink_dark_frames", cnt, 2);
`else
    chkint("blink_dark_frames", cnt, 0);
`endif

    // Reset in slot 5 clears at once; restart after SD edges.
    wait_frame();
    repeat (5 * SD) @(posedge CP);
    @(negedge CP);
    _CR = 1'b0;
    #1;
    chk8("midreset_sel", bus.select_light, 8'h00);
    chk8("midreset_char", bus.display_char, 8'h00);
    repeat (3) @(negedge CP);
    _CR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CP); #2;
      chk8("restart_wait_sel", bus.select_light, 8'h00);
    end
    @(posedge CP); #2;
    chk8("restart_sel", bus.select_light, 8'h01);
    chk8("restart_fs", {7'd0, bus.frame_start}, 8'h01);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CP);
      if ($urandom_range(3, 0) == 0) begin
        bus.digits     = $urandom;
        bus.dp_mask    = 8'($urandom);
        bus.blink_mask = 8'($urandom);
      end
      if ($urandom_range(499, 0) == 0) begin
        _CR = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge CP);
        _CR = 1'b1;
      end
    end

    repeat (2) @(posedge CP);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the 8-digit seven-segment display of the digital clock. It takes eight 4-bit digit codes plus per-digit decimal-point and blink masks from the timekeeping/adjust logic and scans them onto the board's shared segment bus. It is the stage directly downstream of the clock core and produces `select_light` / `display_char`. Inputs are latched once per frame so the display never tears.

## Interface
- `SCAN_DIV`, 100000: CP cycles per digit slot (1 kHz per digit at 100 MHz).
- `BLINK_FRAMES`, 64: frames per blink half-period; must be ≥1.

- `CP`  in  1  system clock, rising edge.
- `_CR`  in  1  asynchronous active-low reset.
- `digits`  in  32  digit i code = `digits[4i+3:4i]`, i = 0..7.
- `dp_mask`  in  8  bit i lights the decimal point of digit i.
- `blink_mask`  in  8  bit i makes digit i blink (adjust field).
- `select_light`  out  8  one-hot, active-high digit enable; bit i = digit i.
- `display_char`  out  8  active-high segments `{dp,g,f,e,d,c,b,a}`.
- `frame_start`  out  1  one-cycle pulse when digit 0 begins a new frame.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1, wraps. `tick` = (`pre` == SCAN_DIV-1).
- Slot index `idx` (3 bits) increments on `tick` and wraps 7→0.
- Frame boundary = `tick` with `idx` == 7, plus the first `tick` after reset. On it, `digits`, `dp_mask` and `blink_mask` are copied into shadow registers. All decoding uses the shadows only.
- Decode: 0–9 map to the standard glyphs (0 = 8'h3F, 1 = 8'h06, 8 = 8'h7F). 4'hA = dash (8'h40). 4'hB–4'hF = blank (8'h00). The dp bit is ORed in from the shadow `dp_mask[idx]`.
- Blink: frame counter `fc` counts 0..BLINK_FRAMES-1 and advances at each frame boundary. When it wraps, `blink_phase` toggles. While `blink_phase` = 1, a digit whose shadow blink bit is set outputs 8'h00, dp included. Its `select_light` bit still asserts.
- State per slot: DRIVE(idx) → DRIVE(idx+1) on `tick`. No other states; the block free-runs continuously.

## Timing
- Reset (async, `_CR` = 0): `select_light` = 8'h00, `display_char` = 8'h00, `frame_start` = 0. Also `pre` = 0, `idx` = 7, `fc` = 0, `blink_phase` = 0, all shadows 0.
- After `_CR` deasserts, the first `tick` occurs on cycle SCAN_DIV. The cycle after it shows digit 0 with freshly latched inputs, and `frame_start` = 1 for exactly that cycle.
- All outputs are registered. `select_light` and `display_char` change on the same edge, one cycle after `tick`. Each slot lasts exactly SCAN_DIV cycles, so one frame is 8·SCAN_DIV cycles.
- Input changes in mid-frame are invisible until the next frame boundary. An input change in the boundary cycle itself is captured.
- When the frame counter wrap and the shadow load coincide, the new `blink_phase` and the new shadows take effect together from digit 0.
- Reset asserted mid-frame clears everything immediately, with no partial slot completed.
- SCAN_DIV = 1: `tick` is asserted every cycle, and the digit advances every cycle.

## Configuration
- `SEG_BLINK_EN` defined: blink logic (`fc`, `blink_phase`, `blink_mask` shadow) is present as described above.
- Not defined: the blink logic is removed, `blink_mask` is ignored, and digits are always displayed. The `BLINK_FRAMES` parameter and the port list remain unchanged.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_FRAMES = 2.
- Reset then release: both outputs stay at 0 for 4 cycles. Then `select_light` = 8'h01, `frame_start` pulses once, and `select_light` walks 01→02→…→80→01 every 4 cycles.
- `digits` = 32'h76543210, `dp_mask` = 8'h04: the slot display_char sequence is 3F, 06, DB (5B|80), 4F, 66, 6D, 7D, 07.
- Change `digits` in mid-frame, during slot 3: slots 3–7 still show the old values, and the new values appear from the next slot 0.
- With `SEG_BLINK_EN` defined, `blink_mask` = 8'h03: digits 0–1 are lit for 2 frames, then show 8'h00 for 2 frames, and repeat. `select_light` still walks every slot. With the macro undefined, digits 0–1 are never blanked.
- Codes A–F: 4'hA gives 8'h40; B, C, D, E and F give 8'h00.
- Assert `_CR` in slot 5: outputs go to 0 immediately, and the sequence restarts at digit 0 after 4 cycles from release.
